// File: rtl/mem_write_addr_gen.sv
// Write-side address generator for layer output memories: waits LATENCY cycles after start,
// then steps through DEPTH x CHANNELS locations (base-offset) on each accepted result.
module mem_write_addr_gen #(
   parameter int unsigned ADDR_W   = 4,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned LATENCY  = 1,
   parameter bit          CH_MAJOR = 1'b0,
   parameter int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              enable,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] addr,
   output logic [CH_W-1:0]   ch,
   output logic              busy,
   output logic              done,
   output logic              done_pulse
);

   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);
   localparam logic [CH_W-1:0]   LastCh  = CH_W'(CHANNELS - 1);
   localparam logic [3:0]        LatLast = 4'(int'(LATENCY) - 1);

   typedef enum logic [1:0] {StIdle, StPrime, StWrite, StDone} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   idx_q;
   logic [CH_W-1:0]     ch_q;
   logic [3:0]          lat_q;
   logic [ADDR_W-1:0]   base_q;
   logic                busy_q;
   logic                done_q;
   logic                done_pulse_q;
   logic                last_elem;
   logic                write_now;

   assign last_elem = (idx_q == LastIdx) && (ch_q == LastCh);
   assign write_now = enable && in_valid && (state_q == StWrite);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         ch_q         <= '0;
         lat_q        <= '0;
         base_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         done_pulse_q <= 1'b0;
      end else if (enable) begin
         done_pulse_q <= 1'b0;
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  base_q <= base_addr;
                  idx_q  <= '0;
                  ch_q   <= '0;
                  lat_q  <= '0;
                  done_q <= 1'b0;
                  busy_q <= 1'b1;
                  state_q <= (LATENCY > 0) ? StPrime : StWrite;
               end
            end
            StPrime: begin
               if (lat_q == LatLast) begin
                  lat_q   <= '0;
                  state_q <= StWrite;
               end else begin
                  lat_q <= lat_q + 4'd1;
               end
            end
            StWrite: begin
               if (in_valid) begin
                  if (last_elem) begin
                     // Indices stay on the final location so addr/ch report it in DONE.
                     state_q      <= StDone;
                     busy_q       <= 1'b0;
                     done_q       <= 1'b1;
                     done_pulse_q <= 1'b1;
                  end else if (!CH_MAJOR) begin
                     if (idx_q == LastIdx) begin
                        idx_q <= '0;
                        ch_q  <= ch_q + CH_W'(1);
                     end else begin
                        idx_q <= idx_q + ADDR_W'(1);
                     end
                  end else begin
                     if (ch_q == LastCh) begin
                        ch_q  <= '0;
                        idx_q <= idx_q + ADDR_W'(1);
                     end else begin
                        ch_q <= ch_q + CH_W'(1);
                     end
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign wr_en      = write_now;
   assign addr       = base_q + idx_q;
   assign ch         = ch_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_mem_write_addr_gen.sv
// Bench for mem_write_addr_gen: five configurations driven in lockstep and checked against a
// sequence-level model, plus a hand-derived vector table and directed corner sequences.
module tb_mem_write_addr_gen;

   localparam int NDUT = 5;
   localparam int DEP [NDUT] = '{16, 2, 4, 1, 3};
   localparam int CHN [NDUT] = '{4, 4, 1, 1, 2};
   localparam int LAT [NDUT] = '{1, 1, 1, 0, 3};
   localparam int CM  [NDUT] = '{0, 1, 0, 0, 1};

   logic       clk = 1'b0;
   logic       rst, start, enable, in_valid;
   logic [3:0] base_addr;

   logic       wr_w   [NDUT];
   logic [3:0] addr_w [NDUT];
   logic [1:0] ch_w   [NDUT];
   logic       busy_w [NDUT];
   logic       done_w [NDUT];
   logic       dp_w   [NDUT];
   logic [1:0] ch0, ch1;
   logic       ch2, ch3, ch4;

   assign ch_w[0] = ch0;
   assign ch_w[1] = ch1;
   assign ch_w[2] = {1'b0, ch2};
   assign ch_w[3] = {1'b0, ch3};
   assign ch_w[4] = {1'b0, ch4};

   always #5 clk = ~clk;

   mem_write_addr_gen #(.ADDR_W(4), .DEPTH(16), .CHANNELS(4), .LATENCY(1), .CH_MAJOR(1'b0)) u_d0 (
      .clk(clk), .reset(rst), .start(start), .enable(enable), .in_valid(in_valid),
      .base_addr(base_addr), .wr_en(wr_w[0]), .addr(addr_w[0]), .ch(ch0), .busy(busy_w[0]),
      .done(done_w[0]), .done_pulse(dp_w[0]));
   mem_write_addr_gen #(.ADDR_W(4), .DEPTH(2), .CHANNELS(4), .LATENCY(1), .CH_MAJOR(1'b1)) u_d1 (
      .clk(clk), .reset(rst), .start(start), .enable(enable), .in_valid(in_valid),
      .base_addr(base_addr), .wr_en(wr_w[1]), .addr(addr_w[1]), .ch(ch1), .busy(busy_w[1]),
      .done(done_w[1]), .done_pulse(dp_w[1]));
   mem_write_addr_gen #(.ADDR_W(4), .DEPTH(4), .CHANNELS(1), .LATENCY(1), .CH_MAJOR(1'b0)) u_d2 (
      .clk(clk), .reset(rst), .start(start), .enable(enable), .in_valid(in_valid),
      .base_addr(base_addr), .wr_en(wr_w[2]), .addr(addr_w[2]), .ch(ch2), .busy(busy_w[2]),
      .done(done_w[2]), .done_pulse(dp_w[2]));
   mem_write_addr_gen #(.ADDR_W(4), .DEPTH(1), .CHANNELS(1), .LATENCY(0), .CH_MAJOR(1'b0)) u_d3 (
      .clk(clk), .reset(rst), .start(start), .enable(enable), .in_valid(in_valid),
      .base_addr(base_addr), .wr_en(wr_w[3]), .addr(addr_w[3]), .ch(ch3), .busy(busy_w[3]),
      .done(done_w[3]), .done_pulse(dp_w[3]));
   mem_write_addr_gen #(.ADDR_W(4), .DEPTH(3), .CHANNELS(2), .LATENCY(3), .CH_MAJOR(1'b1)) u_d4 (
      .clk(clk), .reset(rst), .start(start), .enable(enable), .in_valid(in_valid),
      .base_addr(base_addr), .wr_en(wr_w[4]), .addr(addr_w[4]), .ch(ch4), .busy(busy_w[4]),
      .done(done_w[4]), .done_pulse(dp_w[4]));

   int nvec = 0;
   int nerr = 0;

   // Model: phase (0 idle, 1 prime, 2 write, 3 done), writes completed, prime cycles left.
   int m_st [NDUT];
   int m_k  [NDUT];
   int m_pr [NDUT];
   int m_base [NDUT];
   int m_p  [NDUT];

   typedef struct {
      logic       rst, start, en, val;
      logic [3:0] base;
      int         e_wr, e_addr, e_busy, e_done, e_dp;
   } vec_t;

   task automatic check(input string nm, input int got, input int exp);
      nvec++;
      if (got != exp) begin
         nerr++;
         $display("FAIL %s actual=%0d required=%0d at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic void loc(input int i, input int kk, output int a, output int c);
      if (CM[i] == 0) begin
         a = kk % DEP[i];
         c = kk / DEP[i];
      end else begin
         c = kk % CHN[i];
         a = kk / CHN[i];
      end
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NDUT; i++) begin
         m_st[i] = 0; m_k[i] = 0; m_pr[i] = 0; m_base[i] = 0; m_p[i] = 0;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < NDUT; i++) begin
         if (!rst) begin
            m_st[i] = 0; m_k[i] = 0; m_pr[i] = 0; m_base[i] = 0; m_p[i] = 0;
         end else if (enable) begin
            m_p[i] = 0;
            case (m_st[i])
               0, 3: if (start) begin
                  m_base[i] = int'(base_addr);
                  m_k[i] = 0;
                  m_pr[i] = LAT[i];
                  m_st[i] = (LAT[i] > 0) ? 1 : 2;
               end
               1: begin
                  m_pr[i]--;
                  if (m_pr[i] == 0) m_st[i] = 2;
               end
               default: if (in_valid) begin
                  m_k[i]++;
                  if (m_k[i] == DEP[i] * CHN[i]) begin
                     m_st[i] = 3;
                     m_p[i] = 1;
                  end
               end
            endcase
         end
      end
   endtask

   task automatic check_models();
      int kk, a, c;
      for (int i = 0; i < NDUT; i++) begin
         kk = (m_st[i] == 3) ? DEP[i] * CHN[i] - 1 : m_k[i];
         loc(i, kk, a, c);
         check($sformatf("d%0d_wr_en", i), int'(wr_w[i]),
               (m_st[i] == 2 && enable && in_valid) ? 1 : 0);
         check($sformatf("d%0d_addr", i), int'(addr_w[i]), (m_base[i] + a) % 16);
         check($sformatf("d%0d_ch", i), int'(ch_w[i]), c);
         check($sformatf("d%0d_busy", i), int'(busy_w[i]), (m_st[i] == 1 || m_st[i] == 2) ? 1 : 0);
         check($sformatf("d%0d_done", i), int'(done_w[i]), (m_st[i] == 3) ? 1 : 0);
         check($sformatf("d%0d_done_pulse", i), int'(dp_w[i]), m_p[i]);
      end
   endtask

   // Drive one cycle's inputs and check all outputs on the falling edge.
   task automatic apply(input logic r, input logic s, input logic e, input logic v,
                        input logic [3:0] b);
      rst = r; start = s; enable = e; in_valid = v; base_addr = b;
      if (!r) model_reset();
      @(negedge clk);
      check_models();
   endtask

   task automatic advance();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   vec_t tbl [13];
   int   strobes;
   bit   seen;

   initial begin
      rst = 1'b0; start = 1'b0; enable = 1'b1; in_valid = 1'b1; base_addr = 4'd0;
      model_reset();

      // Hand-derived trace for the DEPTH=4, CHANNELS=1 instance: base 14 wraps, then restart at 3.
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd14, 0, 0, 0, 0, 0};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd14, 0, 0, 0, 0, 0};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 0, 14, 1, 0, 0};
      tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1, 14, 1, 0, 0};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1, 15, 1, 0, 0};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 0, 0, 1, 0, 0};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1, 0, 1, 0, 0};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1, 1, 1, 0, 0};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 0, 1, 0, 1, 1};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 0, 1, 0, 1, 0};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 0, 1, 0, 1, 0};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 0, 3, 1, 0, 0};
      tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1, 3, 1, 0, 0};
      for (int t = 0; t < 13; t++) begin
         apply(tbl[t].rst, tbl[t].start, tbl[t].en, tbl[t].val, tbl[t].base);
         check($sformatf("tbl%0d_wr_en", t), int'(wr_w[2]), tbl[t].e_wr);
         check($sformatf("tbl%0d_addr", t), int'(addr_w[2]), tbl[t].e_addr);
         check($sformatf("tbl%0d_busy", t), int'(busy_w[2]), tbl[t].e_busy);
         check($sformatf("tbl%0d_done", t), int'(done_w[2]), tbl[t].e_done);
         check($sformatf("tbl%0d_done_pulse", t), int'(dp_w[2]), tbl[t].e_dp);
         advance();
      end

      // Full default pass with continuous valid: exactly 64 strobes, then done.
      apply(1'b0, 1'b0, 1'b1, 1'b1, 4'd0); advance();
      apply(1'b1, 1'b1, 1'b1, 1'b1, 4'd0); advance();
      strobes = 0; seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         apply(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
         if (wr_w[0]) strobes++;
         if (done_w[0]) seen = 1'b1;
         advance();
      end
      check("full_pass_done_seen", int'(seen), 1);
      check("full_pass_strobes", strobes, DEP[0] * CHN[0]);

      // Prime stalls and valid toggling on the LATENCY=3 instance.
      apply(1'b1, 1'b1, 1'b1, 1'b1, 4'd5); advance();
      for (int c = 0; c < 3; c++) begin
         apply(1'b1, 1'b0, 1'b0, 1'b1, 4'd0); advance();
      end
      strobes = 0; seen = 1'b0;
      for (int c = 0; c < 100 && !seen; c++) begin
         apply(1'b1, 1'b0, 1'b1, (c % 4 == 0) || (c % 4 == 3), 4'd0);
         if (wr_w[4]) strobes++;
         if (done_w[4]) seen = 1'b1;
         advance();
      end
      check("stall_done_seen", int'(seen), 1);
      check("stall_strobes", strobes, DEP[4] * CHN[4]);

      // Asynchronous reset after five strobes, then a fresh pass from base 7; a mid-write start
      // with a different base must be ignored.
      apply(1'b1, 1'b1, 1'b1, 1'b1, 4'd0); advance();
      strobes = 0;
      for (int c = 0; c < 50 && strobes < 5; c++) begin
         apply(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
         if (wr_w[0]) strobes++;
         advance();
      end
      check("pre_reset_strobes", strobes, 5);
      rst = 1'b0;
      #1;
      check("async_rst_wr_en", int'(wr_w[0]), 0);
      check("async_rst_addr", int'(addr_w[0]), 0);
      check("async_rst_ch", int'(ch_w[0]), 0);
      check("async_rst_busy", int'(busy_w[0]), 0);
      check("async_rst_done", int'(done_w[0]), 0);
      model_reset();
      apply(1'b0, 1'b0, 1'b1, 1'b1, 4'd0); advance();
      apply(1'b1, 1'b1, 1'b1, 1'b1, 4'd7); advance();
      for (int c = 0; c < 8; c++) begin
         apply(1'b1, c == 4, 1'b1, 1'b1, 4'd9); advance();
      end

      // Randomised traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         apply(($urandom_range(0, 399) != 0), ($urandom_range(0, 19) == 0),
               ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7),
               4'($urandom_range(0, 15)));
         advance();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/mem_write_addr_gen.md
Name: mem_write_addr_gen

Overview:
- Parametrised write-side address generator for layer output memories (conv/pool outputs, any depth, multi-channel).
- Follows a compute stage: waits a fixed pipeline latency after start, then issues one write strobe plus address/channel per accepted result until DEPTH x CHANNELS entries are written. Then it flags done for the layer sequencer.
- Adds a latched base offset, stall-on-invalid, channel-major or address-major ordering and restart, none of which the single-depth pooling counters provide.

Parameters:
- ADDR_W, 4, address output width; addresses wrap modulo 2^ADDR_W.
- DEPTH, 16, entries per channel (1..2^ADDR_W).
- CHANNELS, 4, output channels/banks (>=1).
- LATENCY, 1, idle cycles between start and first write-eligible cycle (0..15).
- CH_MAJOR, 0, 0 = all addresses of channel 0, then channel 1...; 1 = all channels at address 0, then address 1...
- CH_W, max(1,clog2(CHANNELS)), derived channel index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a layer write pass.
- enable  in  1  global advance; low freezes all state.
- in_valid  in  1  result available from compute stage this cycle.
- base_addr  in  ADDR_W  start offset, sampled on accepted start.
- wr_en  out  1  memory write strobe (combinational from state & inputs).
- addr  out  ADDR_W  write address = base + element index, mod 2^ADDR_W.
- ch  out  CH_W  channel/bank select for this write.
- busy  out  1  high in PRIME or WRITE.
- done  out  1  level, high in DONE.
- done_pulse  out  1  registered, high exactly one cycle on entry to DONE.

Behaviour:
- States: IDLE, PRIME, WRITE, DONE. Reset (reset=0, any time, mid-pass included) -> IDLE, element index 0, ch 0, latency counter 0, base 0; wr_en=0, addr=0, ch=0, busy=0, done=0, done_pulse=0.
- All transitions/counter updates require enable=1; enable=0 holds every register. wr_en is forced 0 while enable=0.
- IDLE: start&enable -> latch base_addr, clear indices; go PRIME if LATENCY>0, else WRITE.
- PRIME: latency counter increments each enabled cycle; after LATENCY enabled cycles -> WRITE. No writes.
- WRITE: wr_en = enable & in_valid. On each write, advance by ordering.
- CH_MAJOR=0: address index increments. It wraps to 0 at DEPTH-1, and ch then increments.
- CH_MAJOR=1: ch increments. It wraps to 0 at CHANNELS-1, and the address index then increments.
- in_valid=0 stalls: outputs held, no advance.
- The write of the last element (addr index DEPTH-1, ch CHANNELS-1) moves to DONE on the same edge. Exactly DEPTH*CHANNELS strobes per pass.
- DONE: done=1. done_pulse=1 in the first DONE cycle only. addr/ch show the final written location. wr_en=0.
- start&enable in DONE restarts as from IDLE, latching a new base. done drops on that edge.
- start in PRIME/WRITE is ignored.
- Address arithmetic: addr = base + index, truncated to ADDR_W (overflow wraps, no error).
- DEPTH=1, CHANNELS=1: a single write, then DONE.

Test Plan:
- Defaults, base=0, in_valid=1, enable=1, start pulse -> 1 idle cycle, then 64 consecutive wr_en. addr runs 0..15 for ch0, then ch1..ch3. done_pulse is one cycle after the 64th write.
- CH_MAJOR=1, CHANNELS=4, DEPTH=2 -> (addr,ch) order (0,0),(0,1),(0,2),(0,3),(1,0)..(1,3); exactly 8 strobes.
- base_addr=14, DEPTH=4, CHANNELS=1 -> addr sequence 14,15,0,1 (wrap); done after 4th strobe.
- in_valid toggling 1,0,0,1 and enable low for 3 cycles in PRIME -> no advance or strobe during stalls. PRIME lasts LATENCY enabled cycles; total strobes are unchanged.
- Assert reset low mid-WRITE (after 5 strobes) -> all outputs 0 immediately (async); the next start begins again at base with ch 0.
- In DONE, start with base_addr=3 -> done falls, pass restarts at addr 3. A start issued mid-WRITE has no effect on the sequence.
